// File: rtl/adc_spi_reg_reader_if.sv
// Request/response handshake and 3-wire SPI pins of the ADC register reader.
// The master modport is the reader itself; slave is the requester/pad side.
interface adc_spi_reg_reader_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  spi_sclk;
  logic                  spi_csb;
  logic                  spi_sdio_out;
  logic                  spi_sdio_oe;
  logic                  spi_sdio_in;

  modport master (
    input  start, addr, spi_sdio_in,
    output busy, done, rd_data, spi_sclk, spi_csb, spi_sdio_out, spi_sdio_oe
  );

  modport slave (
    output start, addr, spi_sdio_in,
    input  busy, done, rd_data, spi_sclk, spi_csb, spi_sdio_out, spi_sdio_oe
  );
endinterface

// File: rtl/adc_spi_reg_reader.sv
// Read-side master for the ADC 3-wire SPI config port: sends a 16-bit read
// instruction, turns SDIO around and shifts in one register byte.
module adc_spi_reg_reader #(
  parameter int CLK_DIV    = 10,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adc_spi_reg_reader_if.master bus
);
  localparam int INSTR_W = ADDR_WIDTH + 3;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2((INSTR_W > DATA_WIDTH) ? INSTR_W : DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INSTR, S_DATA, S_HOLD, S_GAP} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   csb_q, csb_d;
  logic                   oe_q, oe_d;
  logic                   sdo_q, sdo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  rx_q, rx_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic phase_end, accept, last_instr_bit, last_data_bit;

  assign phase_end      = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign accept         = (state_q == S_IDLE) && bus.start;
  assign last_instr_bit = (bit_q == BIT_W'(INSTR_W - 1));
  assign last_data_bit  = (bit_q == BIT_W'(DATA_WIDTH - 1));

  // NOTE: every register, shift registers included, is cleared by the async reset so an abort leaves no stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      csb_q     <= 1'b1;
      oe_q      <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      instr_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      csb_q     <= csb_d;
      oe_q      <= oe_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      instr_q   <= instr_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The accept cycle counts as the first SETUP cycle, hence cnt starts at 1.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    state_d = state_q;
    cnt_d   = phase_end ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(1);
          bit_d   = '0;
        end
      end
      S_SETUP: if (phase_end) state_d = S_INSTR;
      S_INSTR: if (phase_end && sclk_q) begin
        if (last_instr_bit) begin
          state_d = S_DATA;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_DATA: if (phase_end && sclk_q) begin
        if (last_data_bit) begin
          state_d = S_HOLD;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_HOLD:  if (phase_end) state_d = S_GAP;
      S_GAP:   if (phase_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sclk_d    = sclk_q;
    csb_d     = csb_q;
    oe_d      = oe_q;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    instr_d   = instr_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        instr_d = {1'b1, 2'b00, bus.addr};
        sdo_d   = instr_d[INSTR_W-1];
        csb_d   = 1'b0;
        oe_d    = 1'b1;
        busy_d  = 1'b1;
        sclk_d  = 1'b0;
      end
      S_INSTR: if (phase_end) begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          // Falling edge after the last instruction bit releases SDIO to the ADC.
          if (last_instr_bit) begin
            oe_d  = 1'b0;
            sdo_d = 1'b0;
          end else begin
            instr_d = instr_q << 1;
            sdo_d   = instr_q[INSTR_W-2];
          end
        end
      end
      S_DATA: if (phase_end) begin
        sclk_d = ~sclk_q;
        if (!sclk_q) rx_d = {rx_q[DATA_WIDTH-2:0], bus.spi_sdio_in};
      end
      S_HOLD: if (phase_end) begin
        csb_d     = 1'b1;
        done_d    = 1'b1;
        rd_data_d = rx_q;
      end
      S_GAP:   if (phase_end) busy_d = 1'b0;
      default: ;
    endcase
  end

  // busy includes the accept cycle so a held start relaunches straight from the IDLE cycle.
  assign bus.busy         = busy_q | accept;
  assign bus.done         = done_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_csb      = csb_q;
  assign bus.spi_sdio_out = sdo_q;
  assign bus.spi_sdio_oe  = oe_q;
endmodule

// File: tb/tb_adc_spi_reg_reader.sv
// Scoreboard bench for adc_spi_reg_reader: ADC pin model, protocol checker and
// a monitor that pops expected reads/status probes queued by the stimulus.
module tb_adc_spi_reg_reader;
  localparam int CLK_DIV    = 10;
  localparam int ADDR_WIDTH = 13;
  localparam int DATA_WIDTH = 8;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  data;
    int          done_cyc;
  } txn_t;

  typedef struct {
    int          at_cyc;
    logic [12:0] status;  // {busy, csb, oe, sclk, done, rd_data}
    string       name;
  } probe_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_spi_reg_reader_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  adc_spi_reg_reader #(
    .CLK_DIV(CLK_DIV), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // ---------------- ADC pin model ----------------
  int          rise_cnt = 0;
  logic [15:0] instr_rx = '0;
  logic [15:0] last_instr = '0;
  logic [7:0]  miso_byte = '0;

  function automatic logic [7:0] adc_reg(input logic [12:0] a);
    case (a)
      13'h0001: return 8'hA5;
      13'h1FFF: return 8'h00;
      13'h00AA: return 8'hFF;
      13'h0123: return 8'h3C;
      13'h00F0: return 8'h5A;
      default:  return 8'h99;
    endcase
  endfunction

  always @(negedge bus.spi_csb or posedge bus.spi_sclk) begin
    if (!bus.spi_sclk) begin
      rise_cnt = 0;
    end else begin
      rise_cnt = rise_cnt + 1;
      if (rise_cnt <= 16) instr_rx = {instr_rx[14:0], bus.spi_sdio_out};
      if (rise_cnt == 16) begin
        last_instr = instr_rx;
        miso_byte  = adc_reg(instr_rx[12:0]);
      end
    end
  end

  always @(negedge bus.spi_sclk) begin
    if (rise_cnt >= 16 && rise_cnt < 24) bus.spi_sdio_in = miso_byte[23 - rise_cnt];
    else bus.spi_sdio_in = 1'b0;
  end

  // ---------------- scoreboard / monitor ----------------
  int     checks = 0;
  int     errors = 0;
  txn_t   exp_q[$];
  probe_t probe_q[$];
  txn_t   cur_t;
  probe_t cur_p;
  logic [12:0] st;
  logic [7:0]  exp_rd = '0;
  int  rises = 0, oe_rises = 0, stab_err = 0, idle_edge_err = 0, oe_idle_err = 0;
  int  csb_high_run = 0;
  bit  seen_txn = 1'b0;
  logic prev_sclk = 1'b0, prev_csb = 1'b1, prev_sdo = 1'b0;
  bit  finish_req = 1'b0, final_done = 1'b0;
  int  stim_timeouts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    st = {bus.busy, bus.spi_csb, bus.spi_sdio_oe, bus.spi_sclk, bus.done, bus.rd_data};
    while (probe_q.size() > 0 && probe_q[0].at_cyc <= cyc) begin
      cur_p = probe_q.pop_front();
      if (cur_p.at_cyc == cyc) check(cur_p.name, 32'(st), 32'(cur_p.status));
      else check("probe_missed", cyc, cur_p.at_cyc);
    end

    if (!reset_n) begin
      rises = 0; oe_rises = 0; stab_err = 0; csb_high_run = 0;
      seen_txn = 1'b0;
      exp_rd = '0;
    end else begin
      if (bus.done) begin
        check("done_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur_t = exp_q.pop_front();
          check("rd_data", 32'(bus.rd_data), 32'(cur_t.data));
          check("done_cycle", cyc, cur_t.done_cyc);
          check("instr_word", 32'(last_instr), 32'(cur_t.instr));
          exp_rd = cur_t.data;
        end
      end
      if (bus.spi_csb && (bus.spi_sclk !== prev_sclk)) idle_edge_err++;
      if (bus.spi_csb && bus.spi_sdio_oe) oe_idle_err++;
      if (prev_csb && !bus.spi_csb) begin
        if (seen_txn) check("csb_gap_ge_10", 32'(csb_high_run >= 10), 32'd1);
        check("rd_data_held", 32'(bus.rd_data), 32'(exp_rd));
        rises = 0; oe_rises = 0; stab_err = 0;
      end
      if (!bus.spi_csb) begin
        if (bus.spi_sclk && !prev_sclk) begin
          rises++;
          if (bus.spi_sdio_oe) oe_rises++;
        end
        if (bus.spi_sclk && prev_sclk && (bus.spi_sdio_out !== prev_sdo)) stab_err++;
        csb_high_run = 0;
      end else begin
        csb_high_run++;
      end
      if (!prev_csb && bus.spi_csb) begin
        check("sclk_rises", rises, 24);
        check("oe_instr_bits", oe_rises, 16);
        check("sdo_stable_high", stab_err, 0);
        seen_txn = 1'b1;
      end
    end

    if (finish_req && !final_done) begin
      check("txn_queue_empty", exp_q.size(), 0);
      check("probe_queue_empty", probe_q.size(), 0);
      check("sclk_edge_csb_high", idle_edge_err, 0);
      check("oe_while_csb_high", oe_idle_err, 0);
      check("stim_timeouts", stim_timeouts, 0);
      final_done = 1'b1;
    end

    prev_sclk = bus.spi_sclk;
    prev_csb  = bus.spi_csb;
    prev_sdo  = bus.spi_sdio_out;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 2000) begin
      tick(1);
      n++;
    end
    if (bus.busy) stim_timeouts++;
  endtask

  task automatic expect_status(input int at, input logic b, input logic cs, input logic oe,
                               input logic sc, input logic dn, input logic [7:0] rd,
                               input string name);
    probe_t p;
    p.at_cyc = at;
    p.status = {b, cs, oe, sc, dn, rd};
    p.name   = name;
    probe_q.push_back(p);
  endtask

  task automatic push_txn(input logic [15:0] instr, input logic [7:0] d, input int done_at);
    txn_t t;
    t.instr    = instr;
    t.data     = d;
    t.done_cyc = done_at;
    exp_q.push_back(t);
  endtask

  task automatic launch(input logic [12:0] a, input logic [15:0] instr, input logic [7:0] d,
                        input bit push, output int t);
    wait_idle();
    bus.addr  = a;
    bus.start = 1'b1;
    t = cyc;
    if (push) push_txn(instr, d, t + 500);
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int t;
    int n;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.addr  = '0;
    tick(2);
    expect_status(cyc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "reset_state");
    tick(2);
    reset_n = 1'b1;
    tick(3);

    // Basic read of 0x001: instruction 0x8001, data 0xA5, done at +500, busy low at +510
    launch(13'h0001, 16'h8001, 8'hA5, 1'b1, t);
    expect_status(t + 1,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "accept_outputs");
    expect_status(t + 500, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, "done_pulse");
    expect_status(t + 501, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "done_one_cycle");
    expect_status(t + 509, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "busy_in_gap");
    expect_status(t + 510, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, "busy_low_after_gap");
    wait_cyc(t + 515);

    // Top address and all-zero / all-one read data
    launch(13'h1FFF, 16'h9FFF, 8'h00, 1'b1, t);
    wait_cyc(t + 515);
    launch(13'h00AA, 16'h80AA, 8'hFF, 1'b1, t);
    wait_cyc(t + 515);

    // start pulses and an addr change mid-transaction are ignored
    launch(13'h00F0, 16'h80F0, 8'h5A, 1'b1, t);
    wait_cyc(t + 50);
    bus.addr = 13'h0001;
    wait_cyc(t + 100);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_cyc(t + 300);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    wait_cyc(t + 515);

    // start held for 1200 cycles: reads accepted at +0, +510, +1020
    wait_idle();
    bus.addr  = 13'h0123;
    bus.start = 1'b1;
    t = cyc;
    push_txn(16'h8123, 8'h3C, t + 500);
    push_txn(16'h8123, 8'h3C, t + 1010);
    push_txn(16'h8123, 8'h3C, t + 1520);
    expect_status(t + 510, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, "b2b_idle_accept");
    expect_status(t + 511, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, "b2b_second_csb");
    wait_cyc(t + 1200);
    bus.start = 1'b0;
    wait_cyc(t + 1535);

    // Reset mid-transaction aborts without done; a fresh read then completes
    launch(13'h0001, 16'h8001, 8'hA5, 1'b0, t);
    wait_cyc(t + 250);
    reset_n = 1'b0;
    expect_status(cyc, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "reset_abort");
    tick(3);
    reset_n = 1'b1;
    tick(12);
    launch(13'h0123, 16'h8123, 8'h3C, 1'b1, t);
    wait_cyc(t + 515);

    n = 0;
    while ((exp_q.size() > 0 || probe_q.size() > 0) && n < 3000) begin
      tick(1);
      n++;
    end
    finish_req = 1'b1;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
